// File: rtl/imm_ctrl_seq.sv
// Hardwired T0-T5 control sequencer for the Mini SRC immediate instructions (ldi/addi/andi/ori, nop, halt).
// Define IMM_CTRL_SEQ_STALL_EN to hold T1 until mem_ready is high.
module imm_ctrl_seq #(
    parameter int OPC_WIDTH = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [OPC_WIDTH-1:0] opcode,
    input  logic                 mem_ready,
    output logic                 PCout,
    output logic                 MARin,
    output logic                 IncPC,
    output logic                 Zlowin,
    output logic                 Zlowout,
    output logic                 PCin,
    output logic                 MDMuxread,
    output logic                 RAMread,
    output logic                 MDRin,
    output logic                 MDRout,
    output logic                 IRin,
    output logic                 Gra,
    output logic                 Grb,
    output logic                 Rin,
    output logic                 Rout,
    output logic                 BAout,
    output logic                 Yin,
    output logic                 CSEout,
    output logic                 ADD,
    output logic                 AND,
    output logic                 OR,
    output logic [2:0]           step,
    output logic                 halted,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] instr_count
);

    // State encoding doubles as the step output.
    localparam logic [2:0] ST_T0   = 3'd0;
    localparam logic [2:0] ST_T1   = 3'd1;
    localparam logic [2:0] ST_T2   = 3'd2;
    localparam logic [2:0] ST_T3   = 3'd3;
    localparam logic [2:0] ST_T4   = 3'd4;
    localparam logic [2:0] ST_T5   = 3'd5;
    localparam logic [2:0] ST_IDLE = 3'd6;
    localparam logic [2:0] ST_HALT = 3'd7;

    localparam logic [OPC_WIDTH-1:0] OP_LDI  = OPC_WIDTH'(5'b00001);
    localparam logic [OPC_WIDTH-1:0] OP_ADDI = OPC_WIDTH'(5'b01100);
    localparam logic [OPC_WIDTH-1:0] OP_ANDI = OPC_WIDTH'(5'b01101);
    localparam logic [OPC_WIDTH-1:0] OP_ORI  = OPC_WIDTH'(5'b01110);
    localparam logic [OPC_WIDTH-1:0] OP_NOP  = OPC_WIDTH'(5'b11010);
    localparam logic [OPC_WIDTH-1:0] OP_HALT = OPC_WIDTH'(5'b11011);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       is_ldi, is_addi, is_andi, is_ori, is_nop, is_halt, is_imm;
    logic       t1_done;
    logic       retire;
    logic       bad_op;

    assign is_ldi  = (opcode == OP_LDI);
    assign is_addi = (opcode == OP_ADDI);
    assign is_andi = (opcode == OP_ANDI);
    assign is_ori  = (opcode == OP_ORI);
    assign is_nop  = (opcode == OP_NOP);
    assign is_halt = (opcode == OP_HALT);
    assign is_imm  = is_ldi | is_addi | is_andi | is_ori;

`ifdef IMM_CTRL_SEQ_STALL_EN
    assign t1_done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign t1_done          = 1'b1;
`endif

    assign bad_op = (state == ST_T3) && !(is_imm || is_nop || is_halt);
    assign retire = (state == ST_T5) || ((state == ST_T3) && (is_nop || is_halt));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_T0;
            ST_T0:   state_nxt = ST_T1;
            ST_T1:   if (t1_done) state_nxt = ST_T2;
            ST_T2:   state_nxt = ST_T3;
            ST_T3: begin
                if (is_imm)      state_nxt = ST_T4;
                else if (is_nop) state_nxt = ST_T0;
                else             state_nxt = ST_HALT;
            end
            ST_T4:   state_nxt = ST_T5;
            ST_T5:   state_nxt = ST_T0;
            default: state_nxt = ST_HALT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= ST_IDLE;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (bad_op) illegal <= 1'b1;
            if (retire) instr_count <= instr_count + CNT_WIDTH'(1);
        end
    end

    assign step   = state;
    assign halted = (state == ST_HALT);

    // Strobes are a pure decode of state, plus opcode in T3/T4.
    always_comb begin
        PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zlowin = 1'b0;
        Zlowout = 1'b0; PCin = 1'b0; MDMuxread = 1'b0; RAMread = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        Yin = 1'b0; CSEout = 1'b0; ADD = 1'b0; AND = 1'b0; OR = 1'b0;
        case (state)
            ST_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
            end
            ST_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; MDMuxread = 1'b1;
                RAMread = 1'b1; MDRin = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            ST_T3: begin
                if (is_imm) begin
                    Grb   = 1'b1;
                    Yin   = 1'b1;
                    BAout = is_ldi;
                    Rout  = !is_ldi;
                end
            end
            ST_T4: begin
                CSEout = 1'b1;
                Zlowin = 1'b1;
                ADD    = is_ldi | is_addi;
                AND    = is_andi;
                OR     = is_ori;
            end
            ST_T5: begin
                Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imm_ctrl_seq.sv
// Directed bench for imm_ctrl_seq: step/strobe sequences, halt/illegal, counter wrap, mid-instruction clear.
module tb_imm_ctrl_seq;

    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          clear, start, mem_ready;
    logic [4:0]    opcode;
    logic          PCout, MARin, IncPC, Zlowin, Zlowout, PCin, MDMuxread, RAMread, MDRin, MDRout, IRin;
    logic          Gra, Grb, Rin, Rout, BAout, Yin, CSEout, ADD, AND, OR;
    logic [2:0]    step;
    logic          halted, illegal;
    logic [CW-1:0] instr_count;

    int n_chk  = 0;
    int n_pass = 0;

    imm_ctrl_seq #(.OPC_WIDTH(5), .CNT_WIDTH(CW)) dut (
        .clock(clock), .clear(clear), .start(start), .opcode(opcode), .mem_ready(mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zlowin(Zlowin), .Zlowout(Zlowout),
        .PCin(PCin), .MDMuxread(MDMuxread), .RAMread(RAMread), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Yin(Yin),
        .CSEout(CSEout), .ADD(ADD), .AND(AND), .OR(OR), .step(step), .halted(halted),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    logic [20:0] strobes;
    assign strobes = {PCout, MARin, IncPC, Zlowin, Zlowout, PCin, MDMuxread, RAMread, MDRin,
                      MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Yin, CSEout, ADD, AND, OR};

    localparam logic [20:0] B_PCOUT = 21'd1 << 20, B_MARIN = 21'd1 << 19, B_INCPC = 21'd1 << 18;
    localparam logic [20:0] B_ZLIN  = 21'd1 << 17, B_ZLOUT = 21'd1 << 16, B_PCIN  = 21'd1 << 15;
    localparam logic [20:0] B_MDMUX = 21'd1 << 14, B_RAMRD = 21'd1 << 13, B_MDRIN = 21'd1 << 12;
    localparam logic [20:0] B_MDROUT = 21'd1 << 11, B_IRIN = 21'd1 << 10, B_GRA   = 21'd1 << 9;
    localparam logic [20:0] B_GRB   = 21'd1 << 8,  B_RIN   = 21'd1 << 7,  B_ROUT  = 21'd1 << 6;
    localparam logic [20:0] B_BAOUT = 21'd1 << 5,  B_YIN   = 21'd1 << 4,  B_CSE   = 21'd1 << 3;
    localparam logic [20:0] B_ADD   = 21'd1 << 2,  B_AND   = 21'd1 << 1,  B_OR    = 21'd1;

    localparam logic [20:0] E_T0     = B_PCOUT | B_MARIN | B_INCPC | B_ZLIN;
    localparam logic [20:0] E_T1     = B_ZLOUT | B_PCIN | B_MDMUX | B_RAMRD | B_MDRIN;
    localparam logic [20:0] E_T2     = B_MDROUT | B_IRIN;
    localparam logic [20:0] E_T3_LDI = B_GRB | B_BAOUT | B_YIN;
    localparam logic [20:0] E_T3_ALU = B_GRB | B_ROUT | B_YIN;
    localparam logic [20:0] E_T4_ADD = B_CSE | B_ZLIN | B_ADD;
    localparam logic [20:0] E_T4_AND = B_CSE | B_ZLIN | B_AND;
    localparam logic [20:0] E_T4_OR  = B_CSE | B_ZLIN | B_OR;
    localparam logic [20:0] E_T5     = B_ZLOUT | B_GRA | B_RIN;

    localparam logic [4:0] OP_LDI = 5'b00001, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI = 5'b01110, OP_NOP  = 5'b11010, OP_HALT = 5'b11011;
    localparam logic [4:0] OP_BAD = 5'b11111;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [2:0] s, input logic [20:0] e);
        chk({tag, ".step"}, 32'(step), 32'(s));
        chk({tag, ".strobes"}, 32'(strobes), 32'(e));
    endtask

    // Expects to be sampling T0 on entry; leaves the bench sampling the next T0.
    task automatic exec_imm(input logic [4:0] op, input logic [20:0] e3, input logic [20:0] e4);
        opcode = op;
        chk_st("T0", 3'd0, E_T0); tick();
        chk_st("T1", 3'd1, E_T1); tick();
        chk_st("T2", 3'd2, E_T2); tick();
        chk_st("T3", 3'd3, e3);   tick();
        chk_st("T4", 3'd4, e4);   tick();
        chk_st("T5", 3'd5, E_T5); tick();
    endtask

    task automatic exec_short(input logic [4:0] op);
        opcode = op;
        chk_st("T0s", 3'd0, E_T0); tick();
        chk_st("T1s", 3'd1, E_T1); tick();
        chk_st("T2s", 3'd2, E_T2); tick();
        chk_st("T3s", 3'd3, 21'd0); tick();
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    initial begin
        clear = 1'b0; start = 1'b0; opcode = OP_NOP;
`ifdef IMM_CTRL_SEQ_STALL_EN
        mem_ready = 1'b1;
`else
        mem_ready = 1'b0;   // must be ignored: T1 never stalls
`endif
        start = 1'b1;
        do_clear();
        start = 1'b0;
        chk_st("rst", 3'd6, 21'd0);
        chk("rst.halted", 32'(halted), 32'd0);
        chk("rst.illegal", 32'(illegal), 32'd0);
        chk("rst.count", 32'(instr_count), 32'd0);
        tick();
        chk("idle_hold", 32'(step), 32'd6);

        // ldi then ori, back-to-back
        start = 1'b1; tick(); start = 1'b0;
        exec_imm(OP_LDI, E_T3_LDI, E_T4_ADD);
        chk("ldi.count", 32'(instr_count), 32'd1);
        exec_imm(OP_ORI, E_T3_ALU, E_T4_OR);
        chk("ori.count", 32'(instr_count), 32'd2);
        chk("ori.next_t0", 32'(step), 32'd0);

        // nop then halt
        exec_short(OP_NOP);
        chk("nop.count", 32'(instr_count), 32'd3);
        chk("nop.next_t0", 32'(step), 32'd0);
        exec_short(OP_HALT);
        chk_st("halt", 3'd7, 21'd0);
        chk("halt.halted", 32'(halted), 32'd1);
        chk("halt.count", 32'(instr_count), 32'd4);
        chk("halt.illegal", 32'(illegal), 32'd0);
        start = 1'b1; tick(); start = 1'b0; tick(); tick();
        chk_st("halt_abs", 3'd7, 21'd0);
        chk("halt_abs.count", 32'(instr_count), 32'd4);

        // illegal opcode
        do_clear();
        chk("clr.count", 32'(instr_count), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        exec_short(OP_BAD);
        chk("ill.step", 32'(step), 32'd7);
        chk("ill.illegal", 32'(illegal), 32'd1);
        chk("ill.halted", 32'(halted), 32'd1);
        chk("ill.count", 32'(instr_count), 32'd0);
        tick();
        chk("ill.sticky", 32'(illegal), 32'd1);
        do_clear();
        chk("ill_clr.step", 32'(step), 32'd6);
        chk("ill_clr.illegal", 32'(illegal), 32'd0);

        // 17 addi with a 4-bit counter: wraps after the 16th
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            exec_imm(OP_ADDI, E_T3_ALU, E_T4_ADD);
            if (i == 15) chk("wrap15", 32'(instr_count), 32'd15);
            if (i == 16) chk("wrap16", 32'(instr_count), 32'd0);
            if (i == 17) chk("wrap17", 32'(instr_count), 32'd1);
        end

        // clear during T4 of andi
        opcode = OP_ANDI;
        tick(); tick(); tick();
        chk_st("andi.T3", 3'd3, E_T3_ALU);
        tick();
        chk_st("andi.T4", 3'd4, E_T4_AND);
        do_clear();
        chk_st("midclr", 3'd6, 21'd0);
        chk("midclr.count", 32'(instr_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("midclr.no_rin", 32'(Rin), 32'd0);
            tick();
        end

`ifdef IMM_CTRL_SEQ_STALL_EN
        // T1 held for 4 cycles by mem_ready low for 3 edges
        opcode = OP_LDI;
        start = 1'b1; tick(); start = 1'b0;
        chk_st("stall.T0", 3'd0, E_T0);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            chk_st("stall.T1", 3'd1, E_T1);
            tick();
        end
        chk_st("stall.T2", 3'd2, E_T2); tick();
        chk_st("stall.T3", 3'd3, E_T3_LDI); tick();
        chk_st("stall.T4", 3'd4, E_T4_ADD); tick();
        chk_st("stall.T5", 3'd5, E_T5); tick();
        chk("stall.count", 32'(instr_count), 32'd1);
        chk("stall.next_t0", 32'(step), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
